// File: rtl/plic_pkg.sv
// -----------------------------------------------------------------------------
// plic_pkg
//   Shared types and constants for the PLIC claim/complete controller.
//   - gw_state_e  : per-source gateway state
//   - INT_ID_NONE : claim ID meaning "no interrupt"
//   - PRIO_W_DEF  : default priority/threshold width
//   - id_width()  : claim/complete ID width for a given source count
// -----------------------------------------------------------------------------
package plic_pkg;

  localparam int PRIO_W_DEF  = 3;
  localparam int INT_ID_NONE = 0;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PEND    = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  // IDs run 0..src_num, so the width must hold src_num itself.
  function automatic int id_width(input int src_num);
    return (src_num < 2) ? 1 : $clog2(src_num + 1);
  endfunction

endpackage

// File: rtl/plic_claim_ctrl_if.sv
// -----------------------------------------------------------------------------
// plic_claim_ctrl_if
//   Claim/complete handshake between the hart-side register access (master)
//   and the claim controller (slave).
//   claim_req    master->slave  one-cycle claim strobe
//   claim_vld    slave->master  one-cycle pulse, claim_id valid
//   claim_id     slave->master  claimed source ID (0 = none), held until next claim
//   complete_vld master->slave  one-cycle complete strobe
//   complete_id  master->slave  ID being completed
// -----------------------------------------------------------------------------
interface plic_claim_ctrl_if #(
  parameter int ID_W = 2
);

  logic            claim_req;
  logic            claim_vld;
  logic [ID_W-1:0] claim_id;
  logic            complete_vld;
  logic [ID_W-1:0] complete_id;

  modport master (
    output claim_req,
    output complete_vld,
    output complete_id,
    input  claim_vld,
    input  claim_id
  );

  modport slave (
    input  claim_req,
    input  complete_vld,
    input  complete_id,
    output claim_vld,
    output claim_id
  );

endinterface

// File: rtl/plic_gateway.sv
// -----------------------------------------------------------------------------
// plic_gateway
//   One interrupt gateway: IDLE -(request)-> PEND -(claim)-> CLAIMED
//   -(complete)-> IDLE. Guarantees at most one interrupt in flight per source.
//   Build option PLIC_EDGE_TRIG_EN: request on rising edge of src_irq only;
//   an edge seen while CLAIMED is held in a sticky flag and pends on return to
//   IDLE (further edges coalesce). Default build is level-sensitive.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   src_irq       raw interrupt line
//   claim_hit     this source is being claimed this cycle
//   complete_hit  complete strobe carries this source's ID
//   pend          gateway is in PEND
//   state         current gateway state
// -----------------------------------------------------------------------------
module plic_gateway
  import plic_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      src_irq,
  input  logic      claim_hit,
  input  logic      complete_hit,
  output logic      pend,
  output gw_state_e state
);

  gw_state_e state_nxt;
  logic      req;

`ifdef PLIC_EDGE_TRIG_EN
  logic irq_q;
  logic sticky;
  logic rise;

  assign rise = src_irq & ~irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      irq_q <= src_irq;
      if ((state == GW_CLAIMED) && rise) begin
        sticky <= 1'b1;
      end else if (state == GW_IDLE) begin
        // Any held edge is consumed by the IDLE->PEND transition this cycle.
        sticky <= 1'b0;
      end
    end
  end

  assign req = rise | sticky;
`else
  assign req = src_irq;
`endif

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    if (rst) state <= GW_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      GW_IDLE:    if (req)          state_nxt = GW_PEND;
      GW_PEND:    if (claim_hit)    state_nxt = GW_CLAIMED;
      GW_CLAIMED: if (complete_hit) state_nxt = GW_IDLE;
      default:                      state_nxt = GW_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pend = (state == GW_PEND);
  end

endmodule

// File: rtl/plic_claim_ctrl.sv
// -----------------------------------------------------------------------------
// plic_claim_ctrl
//   Claim/complete controller for a single hart target. One gateway per source
//   latches requests into pending bits; a combinational priority arbiter picks
//   the best eligible source (highest priority, lowest ID on ties); claim and
//   complete strobes are decoded onto the gateways.
//   Build option PLIC_EDGE_TRIG_EN selects edge-triggered gateways (see
//   plic_gateway); default is level-sensitive.
// Ports
//   clk, rst   clock, synchronous active-high reset
//   src_irq    raw interrupt lines, bit i = source ID i+1
//   src_en     per-source enable
//   src_prio   packed priorities, slice i = source ID i+1, 0 = never eligible
//   threshold  source eligible only if prio > threshold
//   bus        claim/complete handshake (slave side)
//   pending    gateway pending bits
//   irq        registered interrupt request to the hart
// -----------------------------------------------------------------------------
module plic_claim_ctrl
  import plic_pkg::*;
#(
  parameter int SRC_NUM = 2,
  parameter int PRIO_W  = PRIO_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SRC_NUM-1:0]        src_irq,
  input  logic [SRC_NUM-1:0]        src_en,
  input  logic [SRC_NUM*PRIO_W-1:0] src_prio,
  input  logic [PRIO_W-1:0]         threshold,
  plic_claim_ctrl_if.slave          bus,
  output logic [SRC_NUM-1:0]        pending,
  output logic                      irq
);

  localparam int ID_W = id_width(SRC_NUM);

  gw_state_e         gw_state [SRC_NUM];
  logic [SRC_NUM-1:0] claim_hit;
  logic [SRC_NUM-1:0] complete_hit;
  logic [SRC_NUM-1:0] eligible;
  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;

  for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
    plic_gateway u_gw (
      .clk          (clk),
      .rst          (rst),
      .src_irq      (src_irq[i]),
      .claim_hit    (claim_hit[i]),
      .complete_hit (complete_hit[i]),
      .pend         (pending[i]),
      .state        (gw_state[i])
    );

    // Pending latches regardless of enable; enable/threshold only mask here.
    assign eligible[i] = (gw_state[i] == GW_PEND) && src_en[i] &&
                         (src_prio[i*PRIO_W +: PRIO_W] > threshold);

    // Only a PEND gateway reacts to claim_hit, and best_id only names PEND
    // sources, so claim and complete can never collide on one gateway.
    assign claim_hit[i]    = bus.claim_req && (best_id == ID_W'(i + 1));
    // Out-of-range IDs match no gateway; non-CLAIMED gateways ignore the hit.
    assign complete_hit[i] = bus.complete_vld && (bus.complete_id == ID_W'(i + 1));
  end

  // Arbiter: strict '>' keeps the lowest ID on equal priorities. Eligible
  // sources always have prio > threshold >= 0, so best_prio starting at 0
  // never shadows a real winner.
  always_comb begin
    // NOTE: combinational logic uses blocking assignment; the loop relies on
    // best_prio updating immediately within the same evaluation.
    best_id   = ID_W'(INT_ID_NONE);
    best_prio = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (eligible[i] && (src_prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = src_prio[i*PRIO_W +: PRIO_W];
        best_id   = ID_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.claim_vld <= 1'b0;
      bus.claim_id  <= ID_W'(INT_ID_NONE);
      irq           <= 1'b0;
    end else begin
      bus.claim_vld <= bus.claim_req;
      if (bus.claim_req) bus.claim_id <= best_id;
      irq <= (best_id != ID_W'(INT_ID_NONE));
    end
  end

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_plic_claim_ctrl
//   Directed scenarios followed by randomized traffic, all compared every cycle
//   against a behavioural model of pending/in-flight sources. Define
//   PLIC_EDGE_TRIG_EN to build the model and DUT in edge-triggered mode.
// -----------------------------------------------------------------------------
module tb_plic_claim_ctrl;

  localparam int SRC_NUM = 2;
  localparam int PRIO_W  = 3;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [SRC_NUM-1:0]        src_irq;
  logic [SRC_NUM-1:0]        src_en;
  logic [SRC_NUM*PRIO_W-1:0] src_prio;
  logic [PRIO_W-1:0]         threshold;
  logic [SRC_NUM-1:0]        pending;
  logic                      irq;

  plic_claim_ctrl_if #(.ID_W(ID_W)) bus ();

  plic_claim_ctrl #(.SRC_NUM(SRC_NUM), .PRIO_W(PRIO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_irq   (src_irq),
    .src_en    (src_en),
    .src_prio  (src_prio),
    .threshold (threshold),
    .bus       (bus),
    .pending   (pending),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_pend: request latched and waiting; m_busy: claimed, awaiting complete.
  bit m_pend [SRC_NUM];
  bit m_busy [SRC_NUM];
  bit m_prev [SRC_NUM];
  bit m_sticky [SRC_NUM];
  bit m_irq, m_vld;
  int m_id;

  function automatic int prio_of(input int i);
    return int'((src_prio >> (i * PRIO_W)) & 3'h7);
  endfunction

  // Winner = eligible source with largest key prio*16 + (15-i): priority first,
  // then smaller index.
  function automatic int model_best();
    int best_key = -1;
    int best     = 0;
    for (int i = 0; i < SRC_NUM; i++) begin
      int key;
      key = prio_of(i) * 16 + (15 - i);
      if (m_pend[i] && src_en[i] && prio_of(i) > int'(threshold) && key > best_key) begin
        best_key = key;
        best     = i + 1;
      end
    end
    return best;
  endfunction

  task automatic model_step();
    int b;
    if (rst) begin
      for (int i = 0; i < SRC_NUM; i++) begin
        m_pend[i] = 0; m_busy[i] = 0; m_prev[i] = 0; m_sticky[i] = 0;
      end
      m_irq = 0; m_vld = 0; m_id = 0;
      return;
    end
    b     = model_best();
    m_irq = (b != 0);
    m_vld = bus.claim_req;
    if (bus.claim_req) m_id = b;
    for (int i = 0; i < SRC_NUM; i++) begin
      bit req;
`ifdef PLIC_EDGE_TRIG_EN
      bit rise;
      rise = src_irq[i] && !m_prev[i];
      req  = rise || m_sticky[i];
      if (m_busy[i] && rise) m_sticky[i] = 1;
      else if (!m_busy[i] && !m_pend[i]) m_sticky[i] = 0;
      m_prev[i] = src_irq[i];
`else
      req = src_irq[i];
`endif
      if (m_busy[i]) begin
        if (bus.complete_vld && int'(bus.complete_id) == i + 1) m_busy[i] = 0;
      end else if (m_pend[i]) begin
        if (bus.claim_req && b == i + 1) begin
          m_pend[i] = 0;
          m_busy[i] = 1;
        end
      end else if (req) begin
        m_pend[i] = 1;
      end
    end
  endtask

  function automatic logic [SRC_NUM-1:0] m_pending();
    logic [SRC_NUM-1:0] p;
    for (int i = 0; i < SRC_NUM; i++) p[i] = m_pend[i];
    return p;
  endfunction

  // Apply current inputs across one posedge, then compare at the next negedge.
  task automatic cycle();
    model_step();
    @(negedge clk);
    check("pending",   32'(pending),      32'(m_pending()));
    check("irq",       32'(irq),          32'(m_irq));
    check("claim_vld", 32'(bus.claim_vld), 32'(m_vld));
    check("claim_id",  32'(bus.claim_id),  32'(m_id));
  endtask

  task automatic strobes_off();
    bus.claim_req    = 1'b0;
    bus.complete_vld = 1'b0;
    bus.complete_id  = '0;
  endtask

  task automatic do_claim();
    bus.claim_req = 1'b1;
    cycle();
    bus.claim_req = 1'b0;
  endtask

  task automatic do_complete(input int id);
    bus.complete_vld = 1'b1;
    bus.complete_id  = ID_W'(id);
    cycle();
    strobes_off();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    src_irq   = '0;
    src_en    = '1;
    src_prio  = '0;
    threshold = '0;
    strobes_off();
    @(negedge clk);

    // 1: reset and idle claim
    do_reset();
    check("rst_pending", 32'(pending), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_claim_vld", 32'(bus.claim_vld), 0);
    do_claim();
    check("idle_claim_vld", 32'(bus.claim_vld), 1);
    check("idle_claim_id", 32'(bus.claim_id), 0);
    cycle();

    // 2: single source latency, claim, re-pend of held level
    src_prio = {3'd0, 3'd2};
    src_irq  = 2'b01;
    cycle();
    check("s2_pending_t1", 32'(pending), 32'h1);
    check("s2_irq_t1", 32'(irq), 0);
    cycle();
    check("s2_irq_t2", 32'(irq), 1);
    do_claim();
    check("s2_claim_id", 32'(bus.claim_id), 1);
    check("s2_pending_clr", 32'(pending), 0);
    cycle();
    check("s2_irq_drop", 32'(irq), 0);
    do_complete(1);
`ifndef PLIC_EDGE_TRIG_EN
    cycle();
    check("s2_repend", 32'(pending), 32'h1);
`endif
    src_irq = '0;
    do_reset();

    // 3: priority and tie-break
    src_prio = {3'd5, 3'd3};
    src_irq  = 2'b11;
    cycle(); cycle();
    src_irq  = 2'b00;
    do_claim();
    check("s3_prio_id", 32'(bus.claim_id), 2);
    do_reset();
    src_prio = {3'd4, 3'd4};
    src_irq  = 2'b11;
    cycle(); cycle();
    src_irq  = 2'b00;
    do_claim();
    check("s3_tie_id", 32'(bus.claim_id), 1);
    do_claim();
    check("s3_second_id", 32'(bus.claim_id), 2);
    do_reset();

    // 4: threshold and enable masking
    src_prio  = {3'd0, 3'd2};
    threshold = 3'd2;
    src_irq   = 2'b01;
    cycle(); cycle(); cycle();
    check("s4_masked_irq", 32'(irq), 0);
    do_claim();
    check("s4_masked_id", 32'(bus.claim_id), 0);
    threshold = 3'd1;
    cycle();
    check("s4_unmask_irq", 32'(irq), 1);
    src_en = 2'b00;
    cycle(); cycle();
    check("s4_en_mask_irq", 32'(irq), 0);
    src_en = 2'b11;
    threshold = 3'd0;
    cycle();

    // 5: bad completes, then simultaneous claim and complete
    do_claim();                         // src1 now claimed
    do_complete(0);
    do_complete(SRC_NUM + 1);
    do_complete(2);                     // src2 never claimed
    src_irq = 2'b11;                    // src2 requests, src1 dropped while claimed
    src_prio = {3'd3, 3'd2};
    cycle();
    src_irq = 2'b00;
    bus.claim_req    = 1'b1;
    bus.complete_vld = 1'b1;
    bus.complete_id  = ID_W'(1);
    cycle();
    strobes_off();
    check("s5_sim_claim_id", 32'(bus.claim_id), 2);
    cycle();
    do_reset();

`ifdef PLIC_EDGE_TRIG_EN
    // 6: edges during CLAIMED coalesce into one re-pend; held level no re-pend
    src_prio = {3'd0, 3'd2};
    src_irq  = 2'b01; cycle(); src_irq = 2'b00; cycle();
    do_claim();
    src_irq = 2'b01; cycle(); src_irq = 2'b00; cycle();
    src_irq = 2'b01; cycle(); src_irq = 2'b00; cycle();
    do_complete(1);
    cycle();
    check("s6_one_repend", 32'(pending), 32'h1);
    do_claim();
    src_irq = 2'b01;                    // single edge, then held high
    cycle(); cycle();
    do_complete(1);
    do_complete(1);
    cycle(); cycle();
    check("s6_no_repend_held", 32'(pending), 32'h1);
    src_irq = 2'b00;
    do_reset();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) begin
        src_prio  = SRC_NUM*PRIO_W'($urandom);
        threshold = PRIO_W'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 31) == 0) src_en = SRC_NUM'($urandom);
      for (int i = 0; i < SRC_NUM; i++)
        if ($urandom_range(0, 7) == 0) src_irq[i] = ~src_irq[i];
      bus.claim_req    = ($urandom_range(0, 3) == 0);
      bus.complete_vld = ($urandom_range(0, 3) == 0);
      bus.complete_id  = ID_W'($urandom_range(0, 3));
      rst              = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    strobes_off();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
